// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register plus a single-outstanding instruction fetch into IR.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
    parameter int                  PC_WIDTH       = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
    parameter int                  TIMEOUT_CYCLES = 15
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                PC_CLR,
    input  logic                PC_IC,
    input  logic                PR_ID,
    input  logic [15:0]         IM_RDATA,
    input  logic                IM_ACK,
    output logic [PC_WIDTH-1:0] IM_ADDR,
    output logic                IM_REQ,
    output logic [15:0]         IR,
    output logic                IR_VALID,
    output logic [PC_WIDTH-1:0] PC,
    output logic                FETCH_ERR
);
    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state, next_state;
    logic [PC_WIDTH-1:0] fetch_addr;
    logic                start, accept, timeout;

    assign start  = state == IDLE && PR_ID;
    assign accept = state == FETCH && IM_ACK && !PC_CLR;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // An ack or an abort on the limit edge wins over the timeout
    assign timeout = state == FETCH && !IM_ACK && !PC_CLR && cnt == CNT_W'(TIMEOUT_CYCLES - 1);

    // Cycles spent in FETCH; held at zero in IDLE so every fetch starts fresh
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) cnt <= '0;
        else        cnt <= state == FETCH ? cnt + 1'b1 : '0;
    end

    // One-cycle error pulse on the edge after the timeout
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) FETCH_ERR <= 1'b0;
        else        FETCH_ERR <= timeout;
    end
`else
    assign timeout = 1'b0;
    // TIMEOUT_CYCLES has no effect in this build; the comparison is constant false
    assign FETCH_ERR = TIMEOUT_CYCLES < 0;
`endif

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next state: a fetch ends on ack, abort or timeout
    always_comb begin
        next_state = state == IDLE ? (PR_ID ? FETCH : IDLE)
                   : (PC_CLR || IM_ACK || timeout) ? IDLE : FETCH;
    end

    // Outputs: address is frozen to the captured value while a fetch is outstanding
    always_comb begin
        IM_REQ  = state == FETCH;
        IM_ADDR = state == FETCH ? fetch_addr : PC;
    end

    // Program counter; clear has priority over increment
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)      PC <= RESET_PC;
        else if (PC_CLR) PC <= RESET_PC;
        else if (PC_IC)  PC <= PC + 1'b1;
    end

    // Fetch address capture; a simultaneous clear fetches from RESET_PC
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)     fetch_addr <= RESET_PC;
        else if (start) fetch_addr <= PC_CLR ? RESET_PC : PC;
    end

    // Instruction register and its valid flag
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            IR       <= 16'h0000;
            IR_VALID <= 1'b0;
        end else if (accept) begin
            IR       <= IM_RDATA;
            IR_VALID <= 1'b1;
        end else if (timeout) begin
            IR       <= 16'h0000;
        end else if (start) begin
            IR_VALID <= 1'b0;
        end
    end
endmodule
